// File: rtl/cache_bus_arbiter_n.sv
// cache_bus_arbiter_n
// Round-robin arbiter that lets NUM_CLIENTS cache front-ends share one
// memory-side bus. A grant lasts for one whole transaction: a read is a single
// header beat followed by BEATS response beats. A write is a header beat
// followed by BEATS data beats.
// Optional feature: define CACHEARB_WATCHDOG_EN to abort a response phase
// that stalls for TIMEOUT cycles. When it fires, err pulses for one cycle.
module cache_bus_arbiter_n #(
   parameter int DATA_WIDTH  = 64,
   parameter int TAG_WIDTH   = 13,
   parameter int NUM_CLIENTS = 4,
   parameter int BEATS       = 8,
   parameter int TIMEOUT     = 256
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_req,
   input  logic [NUM_CLIENTS*TAG_WIDTH-1:0]  cl_reqtag,
   input  logic [NUM_CLIENTS-1:0]            cl_reqcyc,
   output logic [NUM_CLIENTS-1:0]            cl_reqack,
   output logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_resp,
   output logic [NUM_CLIENTS*TAG_WIDTH-1:0]  cl_resptag,
   output logic [NUM_CLIENTS-1:0]            cl_respcyc,
   input  logic [NUM_CLIENTS-1:0]            cl_respack,
   output logic [DATA_WIDTH-1:0]             bus_req,
   output logic [TAG_WIDTH-1:0]              bus_reqtag,
   output logic                              bus_reqcyc,
   input  logic                              bus_reqack,
   input  logic [DATA_WIDTH-1:0]             bus_resp,
   input  logic [TAG_WIDTH-1:0]              bus_resptag,
   input  logic                              bus_respcyc,
   output logic                              bus_respack,
   output logic [$clog2(NUM_CLIENTS)-1:0]    grant,
   output logic                              busy,
   output logic                              err
);

   localparam int GW = $clog2(NUM_CLIENTS);
   localparam int CW = $clog2(BEATS + 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   lastGrant_q, lastGrant_d;
   logic [CW-1:0]   beatCnt_q, beatCnt_d;
   logic            headerDone_q, headerDone_d;

   logic [GW-1:0]   arbPick, arbIdx;
   logic            arbValid;
   logic            curReqcyc, curRespack;
   logic [TAG_WIDTH-1:0] curTag;
   logic            reqBeat, respBeat, lastBeat, wdFire;

   assign curReqcyc  = cl_reqcyc[grant_q];
   assign curRespack = cl_respack[grant_q];
   assign curTag     = cl_reqtag[grant_q*TAG_WIDTH +: TAG_WIDTH];
   assign reqBeat    = (state_q == REQ) && curReqcyc && bus_reqack;
   assign respBeat   = (state_q == RESP) && bus_respcyc && curRespack;
   assign lastBeat   = (beatCnt_q == CW'(BEATS - 1));

   // Round-robin pick: scan downward so that the closest requester after lastGrant wins
   always_comb begin
      arbValid = 1'b0;
      arbPick  = '0;
      arbIdx   = '0;
      for (int i = NUM_CLIENTS; i >= 1; i--) begin
         arbIdx = GW'((int'(lastGrant_q) + i) % NUM_CLIENTS);
         if (cl_reqcyc[arbIdx]) begin
            arbValid = 1'b1;
            arbPick  = arbIdx;
         end
      end
   end

`ifdef CACHEARB_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] wdCnt_q, wdCnt_d;

   assign wdFire = (state_q == RESP) && !respBeat && (wdCnt_q == WW'(TIMEOUT - 1));

   // Count stalled response cycles; any transfer or leaving RESP restarts the count
   always_comb begin
      wdCnt_d = '0;
      if ((state_q == RESP) && !respBeat && !wdFire) begin
         wdCnt_d = wdCnt_q + 1'b1;
      end
   end

   // Watchdog counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         wdCnt_q <= '0;
      end else begin
         wdCnt_q <= wdCnt_d;
      end
   end
`else
   logic unusedTimeout;
   assign unusedTimeout = (TIMEOUT != 0);
   assign wdFire        = 1'b0;
`endif

   // State and transaction bookkeeping registers; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         lastGrant_q  <= GW'(NUM_CLIENTS - 1);
         beatCnt_q    <= '0;
         headerDone_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         lastGrant_q  <= lastGrant_d;
         beatCnt_q    <= beatCnt_d;
         headerDone_q <= headerDone_d;
      end
   end

   // Next state: the header tag decides read vs write the moment it transfers
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      lastGrant_d  = lastGrant_q;
      beatCnt_d    = beatCnt_q;
      headerDone_d = headerDone_q;
      unique case (state_q)
         IDLE: begin
            if (arbValid) begin
               state_d      = REQ;
               grant_d      = arbPick;
               lastGrant_d  = arbPick;
               beatCnt_d    = '0;
               headerDone_d = 1'b0;
            end
         end
         REQ: begin
            if (reqBeat) begin
               if (!headerDone_q) begin
                  headerDone_d = 1'b1;
                  if (curTag[TAG_WIDTH-1]) begin
                     state_d   = RESP;
                     beatCnt_d = '0;
                  end
               end else if (lastBeat) begin
                  state_d = IDLE;
               end else begin
                  beatCnt_d = beatCnt_q + 1'b1;
               end
            end
         end
         RESP: begin
            if (wdFire) begin
               state_d = IDLE;
            end else if (respBeat) begin
               if (lastBeat) begin
                  state_d = IDLE;
               end else begin
                  beatCnt_d = beatCnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: connect only the granted client to the bus side of the phase we are in
   always_comb begin
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_reqcyc  = 1'b0;
      cl_reqack   = '0;
      cl_resp     = '0;
      cl_resptag  = '0;
      cl_respcyc  = '0;
      bus_respack = 1'b0;
      if (state_q == REQ) begin
         bus_req            = cl_req[grant_q*DATA_WIDTH +: DATA_WIDTH];
         bus_reqtag         = curTag;
         bus_reqcyc         = curReqcyc;
         cl_reqack[grant_q] = bus_reqack;
      end
      if (state_q == RESP) begin
         cl_resp             = {NUM_CLIENTS{bus_resp}};
         cl_resptag          = {NUM_CLIENTS{bus_resptag}};
         cl_respcyc[grant_q] = bus_respcyc;
         bus_respack         = curRespack;
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q != IDLE);
   assign err   = wdFire;

endmodule

// File: tb/tb_cache_bus_arbiter_n.sv
// tb_cache_bus_arbiter_n
// Directed bench for the four-client arbiter. It uses a vector table for the
// read and write flows, plus hand-written sequences for these cases:
// round-robin fairness, reset in the middle of a transaction, and the watchdog.
module tb_cache_bus_arbiter_n;

   localparam int DW = 64;
   localparam int TW = 13;
   localparam int N  = 4;

   logic            clk;
   logic            reset;
   logic [N*DW-1:0] cl_req;
   logic [N*TW-1:0] cl_reqtag;
   logic [N-1:0]    cl_reqcyc;
   logic [N-1:0]    cl_reqack;
   logic [N*DW-1:0] cl_resp;
   logic [N*TW-1:0] cl_resptag;
   logic [N-1:0]    cl_respcyc;
   logic [N-1:0]    cl_respack;
   logic [DW-1:0]   bus_req;
   logic [TW-1:0]   bus_reqtag;
   logic            bus_reqcyc;
   logic            bus_reqack;
   logic [DW-1:0]   bus_resp;
   logic [TW-1:0]   bus_resptag;
   logic            bus_respcyc;
   logic            bus_respack;
   logic [1:0]      grant;
   logic            busy;
   logic            err;

   logic [N-1:0]    rdKind;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      string      name;
      logic [3:0] reqcyc;
      logic [3:0] rd;
      logic       reqAck;
      logic       respCyc;
      logic [3:0] respAck;
      logic       expBusy;
      logic [1:0] expGrant;
      logic [3:0] expClReqack;
      logic       expBusReqcyc;
      logic [3:0] expClRespcyc;
      logic       expBusRespack;
   } vec_t;

   vec_t vecs[$];
   int   expRR[6] = '{0, 1, 3, 0, 1, 3};

   cache_bus_arbiter_n #(
      .DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_CLIENTS(N), .BEATS(8), .TIMEOUT(16)
   ) dut (
      .clk(clk), .reset(reset),
      .cl_req(cl_req), .cl_reqtag(cl_reqtag), .cl_reqcyc(cl_reqcyc), .cl_reqack(cl_reqack),
      .cl_resp(cl_resp), .cl_resptag(cl_resptag), .cl_respcyc(cl_respcyc), .cl_respack(cl_respack),
      .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
      .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
      .grant(grant), .busy(busy), .err(err)
   );

   // 10-time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] clientData(input int i);
      return 64'hA5A5_0000_0000_0000 | 64'(i);
   endfunction

   function automatic logic [TW-1:0] clientTag(input logic rd, input int i);
      return {rd, 12'(12'h100 + i)};
   endfunction

   // Each client presents a fixed data word; its tag MSB follows rdKind
   always_comb begin
      cl_req    = '0;
      cl_reqtag = '0;
      for (int i = 0; i < N; i++) begin
         cl_req[i*DW +: DW]    = clientData(i);
         cl_reqtag[i*TW +: TW] = clientTag(rdKind[i], i);
      end
   end

   // One comparison; a mismatch is counted and reported
   task automatic checkOutput(input string nm, input logic [255:0] act, input logic [255:0] expected);
      vecCount++;
      if (act !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      cl_reqcyc   = v.reqcyc;
      rdKind      = v.rd;
      bus_reqack  = v.reqAck;
      bus_respcyc = v.respCyc;
      cl_respack  = v.respAck;
   endtask

   task automatic addVec(input string nm, input logic [3:0] rc, input logic [3:0] rd,
                         input logic ra, input logic rsc, input logic [3:0] rsa,
                         input logic eb, input logic [1:0] eg, input logic [3:0] ecra,
                         input logic ebrc, input logic [3:0] ecrc, input logic ebra);
      vec_t v;
      v.name = nm; v.reqcyc = rc; v.rd = rd; v.reqAck = ra; v.respCyc = rsc; v.respAck = rsa;
      v.expBusy = eb; v.expGrant = eg; v.expClReqack = ecra; v.expBusReqcyc = ebrc;
      v.expClRespcyc = ecrc; v.expBusRespack = ebra;
      vecs.push_back(v);
   endtask

   // Hold reset across two edges with quiet inputs; returns at posedge+1 with reset still high
   task automatic doReset();
      reset       = 1'b1;
      cl_reqcyc   = '0;
      rdKind      = '0;
      cl_respack  = '0;
      bus_reqack  = 1'b0;
      bus_resp    = '0;
      bus_resptag = '0;
      bus_respcyc = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Main sequence: reset check, vector table, then multi-cycle corner cases
   initial begin
      int waited;

      doReset();
      #2;
      checkOutput("rst bus_req", bus_req, 0);
      checkOutput("rst bus_reqtag", bus_reqtag, 0);
      checkOutput("rst bus_reqcyc", bus_reqcyc, 0);
      checkOutput("rst cl_reqack", cl_reqack, 0);
      checkOutput("rst cl_resp", cl_resp, 0);
      checkOutput("rst cl_resptag", cl_resptag, 0);
      checkOutput("rst cl_respcyc", cl_respcyc, 0);
      checkOutput("rst bus_respack", bus_respack, 0);
      checkOutput("rst grant", grant, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst err", err, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Client 2 reads: the response phase has stalls, a gap, and stray acks from other clients
      addVec("A idle arb", 4'b0100, 4'b0100, 1'b0, 1'b1, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0);
      addVec("A header",   4'b0100, 4'b0100, 1'b1, 1'b1, 4'b1111, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0);
      for (int i = 0; i < 2; i++)
         addVec("A beat",  4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0100, 1'b1);
      for (int i = 0; i < 5; i++)
         addVec("A stall", 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1011, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0100, 1'b0);
      addVec("A gap",      4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b1);
      for (int i = 0; i < 6; i++)
         addVec("A beat",  4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0100, 1'b1);
      addVec("A done",     4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0);

      // Client 1 writes while the ack toggles; its tag MSB flips to read after the header
      addVec("C idle arb", 4'b0010, 4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0);
      addVec("C header",   4'b0010, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0000, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         addVec("C wait",  4'b0010, 4'b0010, 1'b0, 1'b1, 4'b1111, 1'b1, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0);
         if (k == 4) begin
            addVec("C drop", 4'b0100, 4'b0010, 1'b1, 1'b1, 4'b1111, 1'b1, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b0);
            addVec("C drop", 4'b0100, 4'b0010, 1'b1, 1'b1, 4'b1111, 1'b1, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b0);
         end
         addVec("C data",  4'b0010, 4'b0010, 1'b1, 1'b1, 4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0000, 1'b0);
      end
      addVec("C done",     4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000, 1'b0);

      foreach (vecs[k]) begin
         applyStimulus(vecs[k]);
         #2;
         checkOutput({vecs[k].name, " busy"}, busy, vecs[k].expBusy);
         checkOutput({vecs[k].name, " grant"}, grant, vecs[k].expGrant);
         checkOutput({vecs[k].name, " cl_reqack"}, cl_reqack, vecs[k].expClReqack);
         checkOutput({vecs[k].name, " bus_reqcyc"}, bus_reqcyc, vecs[k].expBusReqcyc);
         checkOutput({vecs[k].name, " cl_respcyc"}, cl_respcyc, vecs[k].expClRespcyc);
         checkOutput({vecs[k].name, " bus_respack"}, bus_respack, vecs[k].expBusRespack);
         @(posedge clk); #1;
      end

      // Round robin: clients 0, 1 and 3 keep requesting reads, and every phase is accepted at once
      doReset();
      reset       = 1'b0;
      cl_reqcyc   = 4'b1011;
      rdKind      = 4'b1111;
      bus_reqack  = 1'b1;
      bus_respcyc = 1'b1;
      cl_respack  = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         waited = 0;
         #2;
         while (bus_reqcyc !== 1'b1 && waited < 30) begin
            @(posedge clk); #3;
            waited++;
         end
         checkOutput("B wait bound", (waited < 30), 1);
         checkOutput("B grant", grant, expRR[k]);
         checkOutput("B bus_req", bus_req, clientData(expRR[k]));
         checkOutput("B bus_reqtag", bus_reqtag, clientTag(1'b1, expRR[k]));
         @(posedge clk); #1;
      end

      // Reset during the fourth response beat of a client-1 read; afterwards client 0 must win over client 2
      doReset();
      reset = 1'b0;
      @(posedge clk); #1;
      cl_reqcyc  = 4'b0010;
      rdKind     = 4'b0010;
      bus_reqack = 1'b1;
      @(posedge clk); #1;
      #2;
      checkOutput("D grant", grant, 1);
      checkOutput("D bus_req", bus_req, clientData(1));
      @(posedge clk); #1;
      cl_reqcyc   = 4'b0000;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b1;
      cl_respack  = 4'b0010;
      bus_resp    = 64'hDEAD_BEEF_0123_4567;
      bus_resptag = 13'h0ABC;
      #2;
      checkOutput("D cl_resp", cl_resp, {4{64'hDEAD_BEEF_0123_4567}});
      checkOutput("D cl_resptag", cl_resptag, {4{13'h0ABC}});
      checkOutput("D cl_respcyc", cl_respcyc, 4'b0010);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset     = 1'b0;
      cl_reqcyc = 4'b0101;
      rdKind    = 4'b0000;
      #2;
      checkOutput("D post busy", busy, 0);
      checkOutput("D post cl_respcyc", cl_respcyc, 0);
      checkOutput("D post bus_respack", bus_respack, 0);
      checkOutput("D post cl_resp", cl_resp, 0);
      checkOutput("D post bus_reqcyc", bus_reqcyc, 0);
      checkOutput("D post grant", grant, 0);
      checkOutput("D post err", err, 0);
      @(posedge clk); #1;
      #2;
      checkOutput("D regrant", grant, 0);
      checkOutput("D regrant busy", busy, 1);

      // Watchdog: a read from client 0 receives no response beats after the header
      doReset();
      reset = 1'b0;
      @(posedge clk); #1;
      cl_reqcyc  = 4'b0001;
      rdKind     = 4'b0001;
      bus_reqack = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cl_reqcyc  = 4'b0000;
      bus_reqack = 1'b0;
      for (int k = 0; k < 40; k++) begin
         #2;
`ifdef CACHEARB_WATCHDOG_EN
         checkOutput("E err", err, (k == 15));
         checkOutput("E busy", busy, (k <= 15));
`else
         checkOutput("E err", err, 0);
         checkOutput("E busy", busy, 1);
`endif
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
